// File: rtl/vpifo_req_sched.sv
// vpifo_req_sched: request scheduler placed in front of the vPIFO IO port.
//
// Clients queue push/pop commands per virtual tree; one command is issued to the
// IO port per issue slot, trees served round-robin. A failed issue backs off and
// retries the same head, dropping it after RETRY_MAX consecutive failures. Pop
// data from the IO port (all-ones = empty) is registered with a valid tag.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_*, o_req_ready  client command ingress (ready = target FIFO not full)
//   o_tree_id, o_push, o_push_data, o_pop   registered command to the IO port
//   i_task_fail           IO port failure for the tree on o_tree_id
//   i_pop_data            IO port pop data, all-ones means no data
//   o_pop_valid, o_pop_data                 registered pop result
//   o_drop, o_drop_tree_id                  pulse when a command is dropped
module vpifo_req_sched #(
    parameter int unsigned PTW       = 16,
    parameter int unsigned MTW       = 0,
    parameter int unsigned TREE_NUM  = 4,
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned BACKOFF   = 3,
    parameter int unsigned RETRY_MAX = 4,
    localparam int unsigned TW       = $clog2(TREE_NUM),
    localparam int unsigned DW       = MTW + PTW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    input  logic          i_req_push,
    input  logic [TW-1:0] i_req_tree_id,
    input  logic [DW-1:0] i_req_data,
    output logic          o_req_ready,
    output logic [TW-1:0] o_tree_id,
    output logic          o_push,
    output logic [DW-1:0] o_push_data,
    output logic          o_pop,
    input  logic          i_task_fail,
    input  logic [DW-1:0] i_pop_data,
    output logic          o_pop_valid,
    output logic [DW-1:0] o_pop_data,
    output logic          o_drop,
    output logic [TW-1:0] o_drop_tree_id
);

    localparam int unsigned QW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned RW = $clog2(RETRY_MAX + 1);
    localparam int unsigned BW = $clog2(BACKOFF + 1);
    localparam int unsigned EW = DW + 1;  // {push flag, data}

    typedef enum logic [1:0] {StArb, StIssue, StBackoff} state_e;

    // ------------------------------------------------------------------
    // Per-tree command FIFOs
    // ------------------------------------------------------------------
    logic [EW-1:0]       mem_q    [TREE_NUM][QDEPTH];
    logic [QW-1:0]       rd_ptr_q [TREE_NUM];
    logic [QW-1:0]       wr_ptr_q [TREE_NUM];
    logic [CW-1:0]       cnt_q    [TREE_NUM];
    logic [TREE_NUM-1:0] full;
    logic [TREE_NUM-1:0] empty;
    logic [TREE_NUM-1:0] enq;
    logic [TREE_NUM-1:0] deq;
    logic                deq_en;
    logic [TW-1:0]       deq_tree;

    always_comb begin
        for (int t = 0; t < TREE_NUM; t++) begin
            full[t]  = (cnt_q[t] == CW'(QDEPTH));
            empty[t] = (cnt_q[t] == '0);
        end
    end

    assign o_req_ready = ~full[i_req_tree_id];

    always_comb begin
        for (int t = 0; t < TREE_NUM; t++) begin
            enq[t] = i_req_valid && o_req_ready && (i_req_tree_id == TW'(t));
            deq[t] = deq_en && (deq_tree == TW'(t));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < TREE_NUM; t++) begin
                rd_ptr_q[t] <= '0;
                wr_ptr_q[t] <= '0;
                cnt_q[t]    <= '0;
            end
        end else begin
            for (int t = 0; t < TREE_NUM; t++) begin
                if (enq[t]) wr_ptr_q[t] <= wr_ptr_q[t] + QW'(1);
                if (deq[t]) rd_ptr_q[t] <= rd_ptr_q[t] + QW'(1);
                if (enq[t] && !deq[t]) begin
                    cnt_q[t] <= cnt_q[t] + CW'(1);
                end else if (!enq[t] && deq[t]) begin
                    cnt_q[t] <= cnt_q[t] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int t = 0; t < TREE_NUM; t++) begin
            if (enq[t]) mem_q[t][wr_ptr_q[t]] <= {i_req_push, i_req_data};
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first non-empty tree at or after rr_ptr_q
    // ------------------------------------------------------------------
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic          arb_found;
    logic [TW-1:0] arb_tree;
    logic [TW-1:0] arb_idx;
    logic [EW-1:0] head;

    always_comb begin
        arb_found = 1'b0;
        arb_tree  = rr_ptr_q;
        arb_idx   = '0;
        for (int i = 0; i < TREE_NUM; i++) begin
            arb_idx = rr_ptr_q + TW'(i);  // wraps modulo TREE_NUM
            if (!arb_found && !empty[arb_idx]) begin
                arb_found = 1'b1;
                arb_tree  = arb_idx;
            end
        end
    end

    assign head = mem_q[arb_tree][rd_ptr_q[arb_tree]];

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [BW-1:0] bo_cnt_q, bo_cnt_d;
    logic [TW-1:0] tree_q, tree_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic [DW-1:0] push_data_q, push_data_d;
    logic          cmd_push_q, cmd_push_d;  // kind of the held command, for reissue
    logic          drop_q, drop_d;
    logic [TW-1:0] drop_tree_q, drop_tree_d;
    logic          pop_valid_q;
    logic [DW-1:0] pop_data_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        retry_d     = retry_q;
        bo_cnt_d    = bo_cnt_q;
        tree_d      = tree_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        push_data_d = push_data_q;
        cmd_push_d  = cmd_push_q;
        drop_d      = 1'b0;
        drop_tree_d = drop_tree_q;
        deq_en      = 1'b0;
        deq_tree    = tree_q;

        unique case (state_q)
            StArb: begin
                if (arb_found) begin
                    tree_d      = arb_tree;
                    cmd_push_d  = head[DW];
                    push_d      = head[DW];
                    pop_d       = ~head[DW];
                    push_data_d = head[DW] ? head[DW-1:0] : '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (!i_task_fail) begin
                    deq_en   = 1'b1;
                    retry_d  = '0;
                    rr_ptr_d = tree_q + TW'(1);
                    state_d  = StArb;
                end else if (retry_q == RW'(RETRY_MAX - 1)) begin
                    // Last allowed attempt failed: discard the head.
                    deq_en      = 1'b1;
                    drop_d      = 1'b1;
                    drop_tree_d = tree_q;
                    retry_d     = '0;
                    rr_ptr_d    = tree_q + TW'(1);
                    state_d     = StArb;
                end else begin
                    retry_d  = retry_q + RW'(1);
                    // Reissue is registered on the cycle the counter hits 0,
                    // giving exactly BACKOFF idle cycles.
                    bo_cnt_d = BW'(BACKOFF - 1);
                    state_d  = StBackoff;
                end
            end
            StBackoff: begin
                if (bo_cnt_q == '0) begin
                    push_d  = cmd_push_q;
                    pop_d   = ~cmd_push_q;
                    state_d = StIssue;
                end else begin
                    bo_cnt_d = bo_cnt_q - BW'(1);
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StArb;
            rr_ptr_q    <= '0;
            retry_q     <= '0;
            bo_cnt_q    <= '0;
            tree_q      <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            push_data_q <= '0;
            cmd_push_q  <= 1'b0;
            drop_q      <= 1'b0;
            drop_tree_q <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            retry_q     <= retry_d;
            bo_cnt_q    <= bo_cnt_d;
            tree_q      <= tree_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            push_data_q <= push_data_d;
            cmd_push_q  <= cmd_push_d;
            drop_q      <= drop_d;
            drop_tree_q <= drop_tree_d;
            pop_valid_q <= (i_pop_data != '1);
            pop_data_q  <= i_pop_data;
        end
    end

    assign o_tree_id      = tree_q;
    assign o_push         = push_q;
    assign o_pop          = pop_q;
    assign o_push_data    = push_data_q;
    assign o_drop         = drop_q;
    assign o_drop_tree_id = drop_tree_q;
    assign o_pop_valid    = pop_valid_q;
    assign o_pop_data     = pop_data_q;

endmodule

// File: tb/tb_vpifo_req_sched.sv
// Testbench for vpifo_req_sched: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the scheduler.
module tb_vpifo_req_sched;

    localparam int unsigned PTW       = 16;
    localparam int unsigned MTW       = 0;
    localparam int unsigned TREE_NUM  = 4;
    localparam int unsigned QDEPTH    = 4;
    localparam int unsigned BACKOFF   = 3;
    localparam int unsigned RETRY_MAX = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_push = 1'b0;
    logic [1:0]  i_req_tree_id = '0;
    logic [15:0] i_req_data = '0;
    logic        o_req_ready;
    logic [1:0]  o_tree_id;
    logic        o_push;
    logic [15:0] o_push_data;
    logic        o_pop;
    logic        i_task_fail = 1'b0;
    logic [15:0] i_pop_data = 16'hFFFF;
    logic        o_pop_valid;
    logic [15:0] o_pop_data;
    logic        o_drop;
    logic [1:0]  o_drop_tree_id;

    always #5 i_clk = ~i_clk;

    vpifo_req_sched #(
        .PTW       (PTW),
        .MTW       (MTW),
        .TREE_NUM  (TREE_NUM),
        .QDEPTH    (QDEPTH),
        .BACKOFF   (BACKOFF),
        .RETRY_MAX (RETRY_MAX)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .i_req_push     (i_req_push),
        .i_req_tree_id  (i_req_tree_id),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .o_tree_id      (o_tree_id),
        .o_push         (o_push),
        .o_push_data    (o_push_data),
        .o_pop          (o_pop),
        .i_task_fail    (i_task_fail),
        .i_pop_data     (i_pop_data),
        .o_pop_valid    (o_pop_valid),
        .o_pop_data     (o_pop_data),
        .o_drop         (o_drop),
        .o_drop_tree_id (o_drop_tree_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: queued commands per tree plus the scheduler's slot state.
    logic [16:0] q [TREE_NUM][$];
    int          m_rr, m_fails, m_left, m_tree, m_drop_tree;
    bit          m_wait;
    logic [16:0] m_cur;
    logic [15:0] m_pdata, exp_pd;
    bit          exp_push, exp_pop, exp_drop, exp_pv;

    int issue_log[$];
    int push_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < TREE_NUM; t++) q[t].delete();
        m_rr = 0; m_fails = 0; m_left = 0; m_wait = 0; m_tree = 0; m_drop_tree = 0;
        m_cur = '0; m_pdata = '0;
        exp_push = 0; exp_pop = 0; exp_drop = 0; exp_pv = 0; exp_pd = 16'hFFFF;
    endtask

    // One clock cycle: drive inputs, compare all outputs, advance the model.
    task automatic step(input bit v, input bit p, input int tr, input logic [15:0] d,
                        input bit f, input logic [15:0] pd);
        bit rdy, n_push, n_pop, n_drop, found;
        int t;
        i_req_valid = v; i_req_push = p; i_req_tree_id = 2'(tr); i_req_data = d;
        i_task_fail = f; i_pop_data = pd;
        #1;
        if (o_push || o_pop) begin
            issue_log.push_back(int'(o_tree_id));
            push_cyc.push_back(cyc);
        end
        rdy = (q[tr].size() < QDEPTH);
        chk("req_ready", o_req_ready, rdy);
        chk("push", o_push, exp_push);
        chk("pop", o_pop, exp_pop);
        chk("tree_id", o_tree_id, 32'(m_tree));
        chk("push_data", o_push_data, m_pdata);
        chk("drop", o_drop, exp_drop);
        chk("drop_tree", o_drop_tree_id, 32'(m_drop_tree));
        chk("pop_valid", o_pop_valid, exp_pv);
        chk("pop_data", o_pop_data, exp_pd);

        n_push = 0; n_pop = 0; n_drop = 0;
        if (exp_push || exp_pop) begin
            if (!f) begin
                void'(q[m_tree].pop_front());
                m_rr = (m_tree + 1) % TREE_NUM;
                m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails == RETRY_MAX) begin
                    void'(q[m_tree].pop_front());
                    n_drop = 1;
                    m_drop_tree = m_tree;
                    m_rr = (m_tree + 1) % TREE_NUM;
                    m_fails = 0;
                end else begin
                    m_wait = 1;
                    m_left = BACKOFF;
                end
            end
        end else if (m_wait) begin
            m_left--;
            if (m_left == 0) begin
                m_wait = 0;
                n_push = m_cur[16];
                n_pop = !m_cur[16];
            end
        end else begin
            found = 0;
            for (int i = 0; i < TREE_NUM; i++) begin
                t = (m_rr + i) % TREE_NUM;
                if (!found && q[t].size() != 0) begin
                    found = 1;
                    m_tree = t;
                    m_cur = q[t][0];
                    n_push = m_cur[16];
                    n_pop = !m_cur[16];
                    m_pdata = m_cur[16] ? m_cur[15:0] : 16'h0;
                end
            end
        end
        if (v && rdy) q[tr].push_back({p, d});
        exp_push = n_push; exp_pop = n_pop; exp_drop = n_drop;
        exp_pv = (pd != 16'hFFFF); exp_pd = pd;
        @(posedge i_clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, f, 16'hFFFF);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_req_valid = 1'b0; i_task_fail = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_push", o_push, 0);
        chk("rst_pop", o_pop, 0);
        chk("rst_tree", o_tree_id, 0);
        chk("rst_push_data", o_push_data, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_drop_tree", o_drop_tree_id, 0);
        chk("rst_pop_valid", o_pop_valid, 0);
        chk("rst_pop_data", o_pop_data, 16'hFFFF);
        for (int t = 0; t < TREE_NUM; t++) begin
            i_req_tree_id = 2'(t);
            #1;
            chk("rst_ready", o_req_ready, 1);
        end
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int start, npush, fails_left;
        bit seen_drop, failed_once;
        int exp_order[6];
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // Three pushes to tree 2: issue at t+2, t+4, t+6.
        issue_log.delete(); push_cyc.delete();
        start = cyc;
        step(1, 1, 2, 16'h0011, 0, 16'hFFFF);
        step(1, 1, 2, 16'h0022, 0, 16'hFFFF);
        step(1, 1, 2, 16'h0033, 0, 16'hFFFF);
        idle(6, 0);
        chk("lat_count", push_cyc.size(), 3);
        if (push_cyc.size() == 3) begin
            chk("lat_first", push_cyc[0] - start, 2);
            chk("lat_second", push_cyc[1] - start, 4);
            chk("lat_third", push_cyc[2] - start, 6);
        end

        // Fill tree 1 while every issue fails; then retry exhaustion and drop.
        issue_log.delete(); push_cyc.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 1, 16'h00A0 + 16'(i), 1, 16'hFFFF);
        i_req_tree_id = 2'd1; #1;
        chk("full_ready_t1", o_req_ready, 0);
        i_req_tree_id = 2'd0; #1;
        chk("full_ready_t0", o_req_ready, 1);
        seen_drop = 0;
        for (int i = 0; i < 40 && !seen_drop; i++) begin
            if (o_drop) seen_drop = 1;
            else step(0, 0, 1, 16'h0, 1, 16'hFFFF);
        end
        chk("drop_seen", seen_drop, 1);
        chk("drop_tree_id", o_drop_tree_id, 1);
        chk("attempts", issue_log.size(), RETRY_MAX);
        idle(30, 0);
        chk("after_drop_issues", issue_log.size(), RETRY_MAX + 3);

        // Round-robin ordering.
        issue_log.delete(); push_cyc.delete();
        for (int t = 0; t < 4; t++) step(1, 1, t, 16'h0100 + 16'(t), 0, 16'hFFFF);
        idle(3, 0);
        step(1, 1, 3, 16'h0203, 0, 16'hFFFF);
        step(1, 1, 1, 16'h0201, 0, 16'hFFFF);
        idle(12, 0);
        exp_order = '{0, 1, 2, 3, 1, 3};
        chk("rr_count", issue_log.size(), 6);
        for (int i = 0; i < 6 && i < issue_log.size(); i++) begin
            chk("rr_order", issue_log[i], exp_order[i]);
        end

        // Single failure: three idle cycles, then reissue; no drop.
        issue_log.delete(); push_cyc.delete();
        step(1, 1, 0, 16'hBEEF, 0, 16'hFFFF);
        failed_once = 0; seen_drop = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_drop) seen_drop = 1;
            fails_left = (o_push && !failed_once) ? 1 : 0;
            if (fails_left != 0) failed_once = 1;
            step(0, 0, 0, 16'h0, fails_left != 0, 16'hFFFF);
        end
        chk("bo_count", push_cyc.size(), 2);
        if (push_cyc.size() == 2) chk("bo_gap", push_cyc[1] - push_cyc[0], BACKOFF + 1);
        chk("bo_no_drop", seen_drop, 0);

        // Pop result qualification.
        step(0, 0, 0, 16'h0, 0, 16'h1234);
        chk("pop_valid_data", o_pop_valid, 1);
        chk("pop_data_val", o_pop_data, 16'h1234);
        step(0, 0, 0, 16'h0, 0, 16'hFFFF);
        chk("pop_valid_empty", o_pop_valid, 0);

        // Reset while backing off; queued work must be gone afterwards.
        step(1, 1, 2, 16'h0777, 0, 16'hFFFF);
        step(1, 0, 3, 16'h0, 0, 16'hFFFF);
        step(0, 0, 0, 16'h0, 1, 16'hFFFF);
        idle(1, 0);
        do_reset();
        issue_log.delete(); push_cyc.delete();
        idle(6, 0);
        chk("post_rst_idle", issue_log.size(), 0);
        step(1, 1, 2, 16'h0888, 0, 16'hFFFF);
        idle(4, 0);
        chk("post_rst_one", issue_log.size(), 1);

        // Random traffic against the model.
        npush = 0;
        for (int i = 0; i < 600; i++) begin
            logic [15:0] pd;
            pd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 3) == 0, pd);
            npush++;
        end
        idle(60, 0);
        chk("rand_cycles", npush, 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
